// File: rtl/conv_pipe_pkg.sv
// conv_pipe_pkg
//   Shared definitions for the 3x3 convolution pipeline.
//   - mode_e     : kernel selection codes carried on the 2-bit mode input
//   - sum_width  : width of the signed kernel sum for a given pixel width.
//                  Five guard bits cover the box kernel's nine-pixel total
//                  plus a sign bit, so no kernel intermediate can overflow.
package conv_pipe_pkg;

  typedef enum logic [1:0] {
    MODE_VGRAD   = 2'd0,
    MODE_LAPLACE = 2'd1,
    MODE_HGRAD   = 2'd2,
    MODE_BOX     = 2'd3
  } mode_e;

  localparam int SUM_GUARD_BITS = 5;

  function automatic int sum_width(input int bit_per_pixel);
    return bit_per_pixel + SUM_GUARD_BITS;
  endfunction

endpackage

// File: rtl/conv_pipe_kernel_sum.sv
// conv_kernel_sum
//   Combinational 3x3 kernel sum. Pixels are unsigned and zero-extended into
//   the signed sum domain before any arithmetic.
//   Ports:
//     pixel_0..pixel_8 : unsigned window, row-major, pixel_4 is the centre
//     mode             : kernel select (see conv_pipe_pkg::mode_e)
//     sum              : signed kernel result, SUM_W bits
module conv_kernel_sum
  import conv_pipe_pkg::*;
#(
  parameter int BIT_PER_PIXEL = 8,
  parameter int SUM_W         = sum_width(BIT_PER_PIXEL)
) (
  input  logic        [BIT_PER_PIXEL-1:0] pixel_0,
  input  logic        [BIT_PER_PIXEL-1:0] pixel_1,
  input  logic        [BIT_PER_PIXEL-1:0] pixel_2,
  input  logic        [BIT_PER_PIXEL-1:0] pixel_3,
  input  logic        [BIT_PER_PIXEL-1:0] pixel_4,
  input  logic        [BIT_PER_PIXEL-1:0] pixel_5,
  input  logic        [BIT_PER_PIXEL-1:0] pixel_6,
  input  logic        [BIT_PER_PIXEL-1:0] pixel_7,
  input  logic        [BIT_PER_PIXEL-1:0] pixel_8,
  input  logic        [1:0]               mode,
  output logic signed [SUM_W-1:0]         sum
);

  localparam int EXT_W = SUM_W - BIT_PER_PIXEL;

  logic signed [SUM_W-1:0] p [9];
  logic signed [SUM_W-1:0] box_total;

  assign p[0] = $signed({{EXT_W{1'b0}}, pixel_0});
  assign p[1] = $signed({{EXT_W{1'b0}}, pixel_1});
  assign p[2] = $signed({{EXT_W{1'b0}}, pixel_2});
  assign p[3] = $signed({{EXT_W{1'b0}}, pixel_3});
  assign p[4] = $signed({{EXT_W{1'b0}}, pixel_4});
  assign p[5] = $signed({{EXT_W{1'b0}}, pixel_5});
  assign p[6] = $signed({{EXT_W{1'b0}}, pixel_6});
  assign p[7] = $signed({{EXT_W{1'b0}}, pixel_7});
  assign p[8] = $signed({{EXT_W{1'b0}}, pixel_8});

  always_comb begin
    box_total = p[0] + p[1] + p[2] + p[3] + p[4] + p[5] + p[6] + p[7] + p[8];
    sum       = '0;
    case (mode_e'(mode))
      MODE_VGRAD:   sum = p[0] + p[1] + p[2] - p[6] - p[7] - p[8];
      MODE_LAPLACE: sum = p[1] + p[3] + p[5] + p[7] - (p[4] <<< 2);
      MODE_HGRAD:   sum = p[0] + p[3] + p[6] - p[2] - p[5] - p[8];
      MODE_BOX:     sum = box_total >>> 3;
    endcase
  end

endmodule

// File: rtl/conv_pipe.sv
// conv_pipe
//   Two-stage 3x3 convolution pipeline with optional binarisation and a
//   saturating count of above-threshold results.
//   Ports:
//     clk, rst            : clock, synchronous active-high reset
//     in_valid / in_ready : window + config handshake
//     pixel_0..pixel_8    : unsigned 3x3 window, row-major
//     mode                : kernel select
//     threshold           : binarisation / edge threshold (unsigned)
//     binarize_en         : 1 = all-ones/zero output, 0 = magnitude output
//     out_valid/out_ready : result handshake
//     conv_out            : result
//     count_clear         : zeroes edge_count (wins over an increment)
//     edge_count          : saturating count of above-threshold handshakes
module conv_pipe
  import conv_pipe_pkg::*;
#(
  parameter int BIT_PER_PIXEL = 8,
  parameter int COUNT_WIDTH   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [BIT_PER_PIXEL-1:0] pixel_0,
  input  logic [BIT_PER_PIXEL-1:0] pixel_1,
  input  logic [BIT_PER_PIXEL-1:0] pixel_2,
  input  logic [BIT_PER_PIXEL-1:0] pixel_3,
  input  logic [BIT_PER_PIXEL-1:0] pixel_4,
  input  logic [BIT_PER_PIXEL-1:0] pixel_5,
  input  logic [BIT_PER_PIXEL-1:0] pixel_6,
  input  logic [BIT_PER_PIXEL-1:0] pixel_7,
  input  logic [BIT_PER_PIXEL-1:0] pixel_8,
  input  logic [1:0]               mode,
  input  logic [BIT_PER_PIXEL-1:0] threshold,
  input  logic                     binarize_en,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [BIT_PER_PIXEL-1:0] conv_out,
  input  logic                     count_clear,
  output logic [COUNT_WIDTH-1:0]   edge_count
);

  localparam int SUM_W = sum_width(BIT_PER_PIXEL);
  localparam logic [BIT_PER_PIXEL-1:0] PIX_MAX   = '1;
  localparam logic [COUNT_WIDTH-1:0]   COUNT_MAX = '1;

  // |s| clamped to the pixel range.
  function automatic logic [BIT_PER_PIXEL-1:0] sat_mag(input logic signed [SUM_W-1:0] s);
    logic [SUM_W-1:0]         a;
    logic [BIT_PER_PIXEL-1:0] r;
    if (s[SUM_W-1]) a = $unsigned(-s);
    else            a = $unsigned(s);
    if (a > {{(SUM_W-BIT_PER_PIXEL){1'b0}}, PIX_MAX}) r = PIX_MAX;
    else                                              r = a[BIT_PER_PIXEL-1:0];
    return r;
  endfunction

  logic                     advance;
  logic signed [SUM_W-1:0]  sum_c;

  logic                     vld_p1;
  logic signed [SUM_W-1:0]  sum_p1;
  logic [BIT_PER_PIXEL-1:0] thr_p1;
  logic                     bin_p1;
  logic [BIT_PER_PIXEL-1:0] mag_p1;
  logic                     above_p1;

  logic                     vld_p2;
  logic [BIT_PER_PIXEL-1:0] conv_p2;
  logic                     above_p2;
  logic [COUNT_WIDTH-1:0]   edge_cnt;

  // The whole pipe moves together whenever the output slot is free or being
  // drained, so an empty stage never blocks a valid one behind it.
  assign advance  = !vld_p2 || out_ready;
  // Anything taken while rst is high is flushed by that same edge, so the
  // input side can always report ready during reset.
  assign in_ready = rst || advance;

  conv_kernel_sum #(
    .BIT_PER_PIXEL(BIT_PER_PIXEL),
    .SUM_W        (SUM_W)
  ) u_kernel (
    .pixel_0(pixel_0),
    .pixel_1(pixel_1),
    .pixel_2(pixel_2),
    .pixel_3(pixel_3),
    .pixel_4(pixel_4),
    .pixel_5(pixel_5),
    .pixel_6(pixel_6),
    .pixel_7(pixel_7),
    .pixel_8(pixel_8),
    .mode   (mode),
    .sum    (sum_c)
  );

  // Stage 1: kernel sum plus the config captured with the window
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      sum_p1 <= '0;
      thr_p1 <= '0;
      bin_p1 <= 1'b0;
    end else if (advance) begin
      vld_p1 <= in_valid;
      sum_p1 <= sum_c;
      thr_p1 <= threshold;
      bin_p1 <= binarize_en;
    end
  end

  assign mag_p1   = sat_mag(sum_p1);
  assign above_p1 = (mag_p1 >= thr_p1);

  // Stage 2: final output value and above flag
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2   <= 1'b0;
      conv_p2  <= '0;
      above_p2 <= 1'b0;
    end else if (advance) begin
      vld_p2   <= vld_p1;
      conv_p2  <= bin_p1 ? (above_p1 ? PIX_MAX : '0) : mag_p1;
      above_p2 <= above_p1;
    end
  end

  // Output handshake: edge counter
  always_ff @(posedge clk) begin
    if (rst || count_clear) begin
      edge_cnt <= '0;
    end else if (vld_p2 && out_ready && above_p2 && (edge_cnt != COUNT_MAX)) begin
      edge_cnt <= edge_cnt + COUNT_WIDTH'(1);
    end
  end

  assign out_valid  = vld_p2;
  assign conv_out   = conv_p2;
  assign edge_count = edge_cnt;

endmodule

// File: tb/tb_conv_pipe.sv
`timescale 1ns/1ps
module tb_conv_pipe;

  localparam int B = 8;

  typedef struct {
    int conv;
    bit above;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, in_valid, out_ready, binarize_en, count_clear;
  logic [1:0]   mode;
  logic [B-1:0] threshold;
  logic [B-1:0] pix [9];

  logic         in_ready, out_valid;
  logic [B-1:0] conv_out;
  logic [15:0]  edge_count;
  logic         c2_in_ready, c2_out_valid;
  logic [B-1:0] c2_conv_out;
  logic [1:0]   c2_edge_count;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cnt16    = 0;
  int   cnt2     = 0;
  bit   last_acc = 1'b0;
  exp_t sb[$];

  conv_pipe #(.BIT_PER_PIXEL(B), .COUNT_WIDTH(16)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .pixel_0(pix[0]), .pixel_1(pix[1]), .pixel_2(pix[2]), .pixel_3(pix[3]),
    .pixel_4(pix[4]), .pixel_5(pix[5]), .pixel_6(pix[6]), .pixel_7(pix[7]),
    .pixel_8(pix[8]), .mode(mode), .threshold(threshold), .binarize_en(binarize_en),
    .out_valid(out_valid), .out_ready(out_ready), .conv_out(conv_out),
    .count_clear(count_clear), .edge_count(edge_count)
  );

  conv_pipe #(.BIT_PER_PIXEL(B), .COUNT_WIDTH(2)) u_dut_c2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c2_in_ready),
    .pixel_0(pix[0]), .pixel_1(pix[1]), .pixel_2(pix[2]), .pixel_3(pix[3]),
    .pixel_4(pix[4]), .pixel_5(pix[5]), .pixel_6(pix[6]), .pixel_7(pix[7]),
    .pixel_8(pix[8]), .mode(mode), .threshold(threshold), .binarize_en(binarize_en),
    .out_valid(c2_out_valid), .out_ready(out_ready), .conv_out(c2_conv_out),
    .count_clear(count_clear), .edge_count(c2_edge_count)
  );

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // Kernel result straight from the arithmetic definition of each mode.
  function automatic exp_t ref_model(input int p[9], input int md, input int thr, input bit bin);
    int   s;
    int   mag;
    exp_t e;
    case (md)
      0: s = p[0] + p[1] + p[2] - p[6] - p[7] - p[8];
      1: s = p[1] + p[3] + p[5] + p[7] - 4 * p[4];
      2: s = p[0] + p[3] + p[6] - p[2] - p[5] - p[8];
      default: begin
        s = 0;
        foreach (p[i]) s += p[i];
        s = s / 8;
      end
    endcase
    mag = (s < 0) ? -s : s;
    if (mag > 255) mag = 255;
    e.above = (mag >= thr);
    e.conv  = bin ? (e.above ? 255 : 0) : mag;
    return e;
  endfunction

  // Evaluate what the coming clock edge does, using the inputs now applied.
  task automatic predict();
    exp_t e;
    int   pv[9];
    check("in_ready", in_ready, rst || !out_valid || out_ready);
    check("c2_in_ready", c2_in_ready, rst || !out_valid || out_ready);
    last_acc = in_valid && in_ready && !rst;
    if (rst) begin
      sb.delete();
      cnt16 = 0;
      cnt2  = 0;
      return;
    end
    if (out_valid) begin
      if (sb.size() == 0) check("spurious_out", 1, 0);
      else begin
        check("conv_out", conv_out, sb[0].conv);
        if (c2_out_valid) check("c2_conv_out", c2_conv_out, sb[0].conv);
      end
    end
    if (count_clear) begin
      cnt16 = 0;
      cnt2  = 0;
    end
    if (out_valid && out_ready && sb.size() > 0) begin
      e = sb.pop_front();
      if (e.above && !count_clear) begin
        if (cnt16 < 65535) cnt16++;
        if (cnt2 < 3) cnt2++;
      end
    end
    if (in_valid && in_ready) begin
      foreach (pv[i]) pv[i] = int'(pix[i]);
      sb.push_back(ref_model(pv, int'(mode), int'(threshold), binarize_en));
    end
    check("in_flight_le_2", sb.size() <= 2, 1);
  endtask

  task automatic cycle();
    #1;
    predict();
    @(posedge clk);
    @(negedge clk);
    check("edge_count", edge_count, cnt16);
    check("c2_edge_count", c2_edge_count, cnt2);
  endtask

  task automatic set_all(input int v);
    foreach (pix[i]) pix[i] = B'(v);
  endtask

  task automatic rand_window();
    foreach (pix[i]) pix[i] = ($urandom_range(0, 3) == 0) ? 8'hFF : B'($urandom);
    mode        = 2'($urandom);
    threshold   = B'($urandom);
    binarize_en = 1'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (sb.size() > 0 && n < 10) begin
      cycle();
      n++;
    end
    check("drain_empty", sb.size(), 0);
  endtask

  initial begin
    int   acc;
    int   cyc;
    int   first_out;
    bit   stall;
    logic [B-1:0] held;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; mode = 2'd0;
    threshold = '0; binarize_en = 1'b0; count_clear = 1'b0;
    set_all(0);
    cycle();
    cycle();
    check("rst_out_valid", out_valid, 0);
    check("rst_conv_out", conv_out, 0);
    check("rst_edge_count", edge_count, 0);
    rst = 1'b0;
    out_ready = 1'b1;

    // Laplacian, binarised: 400 -> 0xFF two cycles after acceptance
    set_all(0);
    pix[1] = 8'd100; pix[3] = 8'd100; pix[5] = 8'd100; pix[7] = 8'd100;
    mode = 2'd1; threshold = 8'd128; binarize_en = 1'b1; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0; mode = 2'd0; threshold = 8'd255; binarize_en = 1'b0; set_all(7);
    check("lap_lat1_valid", out_valid, 0);
    cycle();
    check("lap_lat2_valid", out_valid, 1);
    check("lap_out", conv_out, 255);
    cycle();
    check("lap_count", edge_count, 1);

    // Vertical gradient -120: magnitude then binarised
    set_all(33);
    pix[0] = 8'd10; pix[1] = 8'd10; pix[2] = 8'd10;
    pix[6] = 8'd50; pix[7] = 8'd50; pix[8] = 8'd50;
    mode = 2'd0; threshold = 8'd128; binarize_en = 1'b0; in_valid = 1'b1;
    cycle();
    binarize_en = 1'b1;
    cycle();
    in_valid = 1'b0;
    check("vgrad_mag", conv_out, 120);
    cycle();
    check("vgrad_bin", conv_out, 0);
    cycle();
    check("vgrad_count", edge_count, 1);

    // Box: saturating and non-saturating
    mode = 2'd3; threshold = 8'd0; binarize_en = 1'b0; set_all(255); in_valid = 1'b1;
    cycle();
    set_all(16);
    cycle();
    in_valid = 1'b0;
    check("box_sat", conv_out, 255);
    cycle();
    check("box_16", conv_out, 18);
    drain();

    // Stream of four windows with a three-cycle output stall
    acc = 0; cyc = 0; first_out = -1; held = '0;
    while ((acc < 4 || sb.size() > 0) && cyc < 40) begin
      rand_window();
      in_valid = (acc < 4);
      if (first_out < 0 && out_valid) begin
        first_out = cyc;
        held = conv_out;
      end
      stall = (first_out >= 0) && (cyc < first_out + 3);
      out_ready = !stall;
      #1;
      if (stall) begin
        check("stall_in_ready", in_ready, 0);
        check("stall_hold", conv_out, held);
      end
      cycle();
      if (last_acc) acc++;
      cyc++;
    end
    check("stream_accepted", acc, 4);
    check("stream_all_out", sb.size(), 0);
    drain();

    // Reset with both stages full
    out_ready = 1'b0; in_valid = 1'b1; rand_window(); threshold = 8'd0;
    cycle();
    rand_window(); threshold = 8'd0;
    cycle();
    check("prerst_full", out_valid, 1);
    rst = 1'b1;
    #1;
    check("rst_in_ready_stalled", in_ready, 1);
    cycle();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    check("rstmid_out_valid", out_valid, 0);
    check("rstmid_conv_out", conv_out, 0);
    check("rstmid_count", edge_count, 0);
    mode = 2'd3; set_all(16); binarize_en = 1'b0; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    check("postrst_lat1", out_valid, 0);
    cycle();
    check("postrst_lat2", out_valid, 1);
    check("postrst_out", conv_out, 18);
    drain();

    // Counter saturation on the 2-bit instance, and clear over increment
    count_clear = 1'b1;
    cycle();
    count_clear = 1'b0;
    check("clr_count", edge_count, 0);
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      rand_window(); threshold = 8'd0;
      cycle();
    end
    drain();
    check("sat_c2", c2_edge_count, 3);
    check("five_c16", edge_count, 5);
    rand_window(); threshold = 8'd0; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0; out_ready = 1'b0;
    cycle();
    check("clr_pre_valid", out_valid, 1);
    out_ready = 1'b1; count_clear = 1'b1;
    cycle();
    count_clear = 1'b0;
    check("clr_wins_c2", c2_edge_count, 0);
    check("clr_wins_c16", edge_count, 0);

    // Randomised traffic
    for (int k = 0; k < 3000; k++) begin
      rand_window();
      in_valid    = ($urandom_range(0, 3) != 0);
      out_ready   = ($urandom_range(0, 3) != 0);
      count_clear = ($urandom_range(0, 63) == 0);
      rst         = ($urandom_range(0, 499) == 0);
      cycle();
    end
    rst = 1'b0; count_clear = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
